// File: rtl/vga_overlay_pkg.sv
// Shared encodings, state type and default screen layout for the digit overlay.
package vga_overlay_pkg;

  // ROM chip-select encodings driven on ROMCS
  localparam logic [1:0] CS_BG   = 2'b00;
  localparam logic [1:0] CS_DIG  = 2'b01;
  localparam logic [1:0] CS_FLAG = 2'b11;

  // Glyph row index used for out-of-range values
  localparam int DASH_INDEX = 10;

  localparam int DEF_NUM_FIELDS = 9;
  localparam int DEF_NUM_FLAGS  = 2;

  // Field 0 occupies the least significant 10 bits
  localparam logic [DEF_NUM_FIELDS*10-1:0] DEF_FIELD_X =
    {10'd339, 10'd429, 10'd519, 10'd416, 10'd232, 10'd132, 10'd38, 10'd128, 10'd218};
  localparam logic [DEF_NUM_FIELDS*10-1:0] DEF_FIELD_Y =
    {10'd288, 10'd288, 10'd288, 10'd130, 10'd130, 10'd130, 10'd288, 10'd288, 10'd288};
  localparam logic [DEF_NUM_FLAGS*10-1:0] DEF_FLAG_X = {10'd500, 10'd338};
  localparam logic [DEF_NUM_FLAGS*10-1:0] DEF_FLAG_Y = {10'd370, 10'd370};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_COMMIT
  } seq_state_e;

endpackage

// File: rtl/vga_digit_overlay_bcd_split.sv
// Splits a 7-bit value into decimal tens/ones digits; flags values above 99.
module bcd_split (
  input  logic [6:0] value,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       invalid
);

  // Constant divisors keep this a small combinational divider
  always_comb begin
    invalid = (value > 7'd99);
    tens    = 4'(value / 7'd10);
    ones    = 4'(value % 7'd10);
  end

endmodule

// File: rtl/vga_digit_overlay.sv
// Per-frame register fetch into a shadow bank, atomic commit, and raster-to-ROM address mapping.
module vga_digit_overlay
  import vga_overlay_pkg::*;
#(
  parameter int NUM_FIELDS   = DEF_NUM_FIELDS,
  parameter int NUM_FLAGS    = DEF_NUM_FLAGS,
  parameter logic [NUM_FIELDS*10-1:0] FIELD_X = DEF_FIELD_X,
  parameter logic [NUM_FIELDS*10-1:0] FIELD_Y = DEF_FIELD_Y,
  parameter logic [NUM_FLAGS*10-1:0]  FLAG_X  = DEF_FLAG_X,
  parameter logic [NUM_FLAGS*10-1:0]  FLAG_Y  = DEF_FLAG_Y,
  parameter int DIG_W        = 40,
  parameter int DIG_H        = 60,
  parameter int DIG_PITCH    = 42,
  parameter int FLAG_W       = 100,
  parameter int FLAG_H       = 20,
  parameter int CURSOR_H     = 5,
  parameter int BLINK_FRAMES = 32,
  parameter int H_RES        = 640,
  parameter int ADDR_W       = 19,
  parameter int MEM_AW       = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [9:0]        PosX,
  input  logic [9:0]        PosY,
  output logic [MEM_AW-1:0] MemAddrOut,
  output logic              MemRdEn,
  input  logic [7:0]        MemDataIN,
  output logic [ADDR_W-1:0] ROMAddrOut,
  output logic [1:0]        ROMCS,
  output logic              Busy
);

  localparam int NREG = NUM_FIELDS + NUM_FLAGS + 1;
  localparam int FCW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [MEM_AW-1:0] NREG_A    = MEM_AW'(NREG);
  localparam logic [ADDR_W-1:0] DIG_W_A   = ADDR_W'(DIG_W);
  localparam logic [ADDR_W-1:0] DIG_H_A   = ADDR_W'(DIG_H);
  localparam logic [ADDR_W-1:0] PITCH_A   = ADDR_W'(DIG_PITCH);
  localparam logic [ADDR_W-1:0] FLAG_W_A  = ADDR_W'(FLAG_W);
  localparam logic [ADDR_W-1:0] FLAG_H_A  = ADDR_W'(FLAG_H);
  localparam logic [ADDR_W-1:0] CUR_H_A   = ADDR_W'(CURSOR_H);
  localparam logic [ADDR_W-1:0] H_RES_A   = ADDR_W'(H_RES);
  localparam logic [FCW-1:0]    FRAME_TOP = FCW'(BLINK_FRAMES - 1);

  seq_state_e state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              cap_pending_q, cap_pending_d;
  logic [MEM_AW-1:0] cap_addr_q, cap_addr_d;

  logic [9:0]           sh_tens_q [NUM_FIELDS];
  logic [9:0]           sh_tens_d [NUM_FIELDS];
  logic [9:0]           sh_ones_q [NUM_FIELDS];
  logic [9:0]           sh_ones_d [NUM_FIELDS];
  logic [NUM_FLAGS-1:0] sh_flag_q, sh_flag_d;
  logic [7:0]           sh_cursor_q, sh_cursor_d;

  logic [9:0]           live_tens_q [NUM_FIELDS];
  logic [9:0]           live_tens_d [NUM_FIELDS];
  logic [9:0]           live_ones_q [NUM_FIELDS];
  logic [9:0]           live_ones_d [NUM_FIELDS];
  logic [NUM_FLAGS-1:0] live_flag_q, live_flag_d;
  logic [7:0]           live_cursor_q, live_cursor_d;

  logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
  logic              blink_q, blink_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [1:0]        cs_q, cs_d;

  logic       frame_start;
  logic [3:0] bcd_tens, bcd_ones;
  logic       bcd_invalid;
  logic [3:0] tens_idx, ones_idx;
  logic [9:0] tens_off, ones_off;

  assign frame_start = (PosX == 10'd0) && (PosY == 10'd0);

  bcd_split u_bcd_split (
    .value   (MemDataIN[6:0]),
    .tens    (bcd_tens),
    .ones    (bcd_ones),
    .invalid (bcd_invalid)
  );

  // Turn incoming digits into glyph row offsets before they reach the shadow bank
  always_comb begin
    tens_idx = bcd_invalid ? 4'(DASH_INDEX) : bcd_tens;
    ones_idx = bcd_invalid ? 4'(DASH_INDEX) : bcd_ones;
    tens_off = 10'(tens_idx) * 10'(DIG_H);
    ones_off = 10'(ones_idx) * 10'(DIG_H);
  end

  // Fetch sequencer: burst reads, shadow capture one cycle behind, single-cycle commit
  always_comb begin
    state_d       = state_q;
    rd_en_d       = 1'b0;
    addr_d        = '0;
    cap_pending_d = rd_en_q;
    cap_addr_d    = addr_q;
    sh_tens_d     = sh_tens_q;
    sh_ones_d     = sh_ones_q;
    sh_flag_d     = sh_flag_q;
    sh_cursor_d   = sh_cursor_q;
    live_tens_d   = live_tens_q;
    live_ones_d   = live_ones_q;
    live_flag_d   = live_flag_q;
    live_cursor_d = live_cursor_q;
    frame_cnt_d   = frame_cnt_q;
    blink_d       = blink_q;

    if (cap_pending_q) begin
      for (int i = 0; i < NUM_FIELDS; i++) begin
        if (cap_addr_q == MEM_AW'(i + 1)) begin
          sh_tens_d[i] = tens_off;
          sh_ones_d[i] = ones_off;
        end
      end
      for (int j = 0; j < NUM_FLAGS; j++) begin
        if (cap_addr_q == MEM_AW'(NUM_FIELDS + 1 + j)) begin
          sh_flag_d[j] = MemDataIN[0];
        end
      end
      if (cap_addr_q == NREG_A) begin
        sh_cursor_d = MemDataIN;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_FETCH;
          rd_en_d = 1'b1;
          addr_d  = MEM_AW'(1);
        end
      end
      ST_FETCH: begin
        if (rd_en_q && (addr_q != NREG_A)) begin
          rd_en_d = 1'b1;
          addr_d  = addr_q + MEM_AW'(1);
        end
        if (cap_pending_q && (cap_addr_q == NREG_A)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        live_tens_d   = sh_tens_q;
        live_ones_d   = sh_ones_q;
        live_flag_d   = sh_flag_q;
        live_cursor_d = sh_cursor_q;
        if (frame_cnt_q == FRAME_TOP) begin
          frame_cnt_d = '0;
          blink_d     = ~blink_q;
        end else begin
          frame_cnt_d = frame_cnt_q + FCW'(1);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Raster mapping: first matching field digit, then flag, otherwise background
  always_comb begin : pixel_map
    logic [ADDR_W-1:0] px, py, ox, oy, off;
    logic              hit;
    px         = ADDR_W'(PosX);
    py         = ADDR_W'(PosY);
    ox         = '0;
    oy         = '0;
    off        = '0;
    hit        = 1'b0;
    rom_addr_d = px + H_RES_A * py;
    cs_d       = CS_BG;

    for (int i = 0; i < NUM_FIELDS; i++) begin
      for (int d = 0; d < 2; d++) begin
        ox  = ADDR_W'(FIELD_X[i*10 +: 10]) + ((d == 1) ? PITCH_A : '0);
        oy  = ADDR_W'(FIELD_Y[i*10 +: 10]);
        off = ADDR_W'((d == 1) ? live_ones_q[i] : live_tens_q[i]);
        if (!hit && (px >= ox) && (px < ox + DIG_W_A) && (py >= oy) && (py < oy + DIG_H_A)) begin
          hit = 1'b1;
          if (!(blink_q && (live_cursor_q == 8'(i + 1)) && (py >= oy + DIG_H_A - CUR_H_A))) begin
            rom_addr_d = (px - ox) + DIG_W_A * ((py - oy) + off);
            cs_d       = CS_DIG;
          end
        end
      end
    end

    for (int j = 0; j < NUM_FLAGS; j++) begin
      ox  = ADDR_W'(FLAG_X[j*10 +: 10]);
      oy  = ADDR_W'(FLAG_Y[j*10 +: 10]);
      off = live_flag_q[j] ? FLAG_H_A : '0;
      if (!hit && (px >= ox) && (px < ox + FLAG_W_A) && (py >= oy) && (py < oy + FLAG_H_A)) begin
        hit        = 1'b1;
        rom_addr_d = (px - ox) + FLAG_W_A * ((py - oy) + off);
        cs_d       = CS_FLAG;
      end
    end
  end

  // State, banks, blink and output registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_IDLE;
      rd_en_q       <= 1'b0;
      addr_q        <= '0;
      cap_pending_q <= 1'b0;
      cap_addr_q    <= '0;
      sh_tens_q     <= '{default: '0};
      sh_ones_q     <= '{default: '0};
      sh_flag_q     <= '0;
      sh_cursor_q   <= '0;
      live_tens_q   <= '{default: '0};
      live_ones_q   <= '{default: '0};
      live_flag_q   <= '0;
      live_cursor_q <= '0;
      frame_cnt_q   <= '0;
      blink_q       <= 1'b0;
      rom_addr_q    <= '0;
      cs_q          <= CS_BG;
    end else begin
      state_q       <= state_d;
      rd_en_q       <= rd_en_d;
      addr_q        <= addr_d;
      cap_pending_q <= cap_pending_d;
      cap_addr_q    <= cap_addr_d;
      sh_tens_q     <= sh_tens_d;
      sh_ones_q     <= sh_ones_d;
      sh_flag_q     <= sh_flag_d;
      sh_cursor_q   <= sh_cursor_d;
      live_tens_q   <= live_tens_d;
      live_ones_q   <= live_ones_d;
      live_flag_q   <= live_flag_d;
      live_cursor_q <= live_cursor_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_q       <= blink_d;
      rom_addr_q    <= rom_addr_d;
      cs_q          <= cs_d;
    end
  end

  assign MemRdEn    = rd_en_q;
  assign MemAddrOut = addr_q;
  assign ROMAddrOut = rom_addr_q;
  assign ROMCS      = cs_q;
  assign Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vga_digit_overlay.sv
// Directed bench for vga_digit_overlay with a small register-file responder.
module tb_vga_digit_overlay;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [9:0]  PosX = 10'd639;
  logic [9:0]  PosY = 10'd479;
  logic [7:0]  MemDataIN = 8'd0;
  logic [3:0]  MemAddrOut;
  logic        MemRdEn;
  logic [18:0] ROMAddrOut;
  logic [1:0]  ROMCS;
  logic        Busy;

  logic [7:0] regs [16];
  int checks = 0;
  int errors = 0;
  int commits = 0;

  vga_digit_overlay dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .PosX       (PosX),
    .PosY       (PosY),
    .MemAddrOut (MemAddrOut),
    .MemRdEn    (MemRdEn),
    .MemDataIN  (MemDataIN),
    .ROMAddrOut (ROMAddrOut),
    .ROMCS      (ROMCS),
    .Busy       (Busy)
  );

  // Free-running pixel clock
  always #5 CLK = ~CLK;

  // Register file returns data the cycle after a read strobe
  always @(posedge CLK) begin
    if (MemRdEn) MemDataIN <= regs[MemAddrOut];
  end

  // Hard stop in case the sequence never completes
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int x, input int y);
    @(negedge CLK);
    PosX = 10'(x);
    PosY = 10'(y);
    @(negedge CLK);
  endtask

  task automatic checkPixel(input string tag, input int x, input int y, input int expAddr, input int expCs);
    applyStimulus(x, y);
    checkOutput({tag, ".addr"}, 32'(ROMAddrOut), 32'(expAddr));
    checkOutput({tag, ".cs"}, 32'(ROMCS), 32'(expCs));
  endtask

  // One full frame fetch; optionally checks the strobe/busy timeline cycle by cycle
  task automatic runFrame(input bit detailed);
    @(negedge CLK);
    PosX = 10'd0;
    PosY = 10'd0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        PosX = 10'd639;
        PosY = 10'd479;
      end
      if (detailed) begin
        checkOutput($sformatf("burst.rden[%0d]", k), 32'(MemRdEn), (k <= 12) ? 32'd1 : 32'd0);
        checkOutput($sformatf("burst.busy[%0d]", k), 32'(Busy), (k <= 14) ? 32'd1 : 32'd0);
        checkOutput($sformatf("burst.addr[%0d]", k), 32'(MemAddrOut), (k <= 12) ? 32'(k) : 32'd0);
      end
    end
    commits++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'd0;

    // Reset state
    repeat (2) @(negedge CLK);
    checkOutput("reset.romaddr", 32'(ROMAddrOut), 32'd0);
    checkOutput("reset.romcs", 32'(ROMCS), 32'd0);
    checkOutput("reset.busy", 32'(Busy), 32'd0);
    checkOutput("reset.rden", 32'(MemRdEn), 32'd0);
    checkOutput("reset.memaddr", 32'(MemAddrOut), 32'd0);
    RESET = 1'b1;

    // Field 0 = 37
    regs[1] = 8'd37;
    runFrame(1'b1);
    checkPixel("f37.ones", 265, 300, 17285, 1);
    checkPixel("f37.tens", 220, 288, 7202, 1);
    checkPixel("f37.bg", 10, 5, 3210, 0);
    checkPixel("f37.left_edge", 217, 288, 184537, 0);
    checkPixel("f37.gap", 258, 288, 184578, 0);
    checkPixel("f37.ones_origin", 260, 288, 16800, 1);
    checkPixel("f37.bottom_edge", 218, 348, 222938, 0);
    checkPixel("f37.last_pixel", 257, 347, 9599, 1);

    // Field 0 = 123 shows dashes
    regs[1] = 8'd123;
    runFrame(1'b0);
    checkPixel("dash.tens", 218, 288, 24000, 1);
    checkPixel("dash.ones", 260, 288, 24000, 1);

    // Flag 0 on, then off
    regs[10] = 8'd1;
    runFrame(1'b0);
    checkPixel("flag.on", 340, 372, 2202, 3);
    checkPixel("flag.on_corner", 437, 389, 3999, 3);
    checkPixel("flag.right_edge", 438, 389, 249398, 0);
    regs[10] = 8'd0;
    runFrame(1'b0);
    checkPixel("flag.off", 340, 372, 202, 3);
    checkPixel("flag1.origin", 500, 370, 0, 3);

    // Cursor on field 0: blank underline while blink phase is 1
    regs[1]  = 8'd37;
    regs[12] = 8'd1;
    while (commits < 70) begin
      runFrame(1'b0);
      if (((commits / 32) % 2) == 1) begin
        checkPixel($sformatf("cursor.on[%0d]", commits), 220, 345, 221020, 0);
      end else begin
        checkPixel($sformatf("cursor.off[%0d]", commits), 220, 345, 9482, 1);
      end
      if (commits == 40) begin
        checkPixel("cursor.ones_blank", 262, 345, 221062, 0);
        checkPixel("cursor.above_rows", 220, 342, 9362, 1);
      end
      if (commits == 66) begin
        checkPixel("cursor.ones_shown", 262, 345, 19082, 1);
      end
    end

    // Out-of-range cursor never blanks, including through phase 1
    regs[12] = 8'd15;
    while (commits < 100) begin
      runFrame(1'b0);
      checkPixel($sformatf("cursor15[%0d]", commits), 220, 345, 9482, 1);
    end

    // Reset in the middle of a burst
    @(negedge CLK);
    PosX = 10'd0;
    PosY = 10'd0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        PosX = 10'd639;
        PosY = 10'd479;
      end
    end
    checkOutput("abort.busy_before", 32'(Busy), 32'd1);
    RESET = 1'b0;
    #1;
    checkOutput("abort.busy", 32'(Busy), 32'd0);
    checkOutput("abort.rden", 32'(MemRdEn), 32'd0);
    checkOutput("abort.memaddr", 32'(MemAddrOut), 32'd0);
    checkOutput("abort.romcs", 32'(ROMCS), 32'd0);
    checkOutput("abort.romaddr", 32'(ROMAddrOut), 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    commits = 0;
    checkPixel("abort.live_zero", 265, 300, 485, 1);
    checkPixel("abort.bg", 10, 5, 3210, 0);
    checkOutput("abort.idle", 32'(Busy), 32'd0);

    // Next frame commits normally
    runFrame(1'b1);
    checkPixel("recover.ones", 265, 300, 17285, 1);
    checkPixel("recover.flag", 340, 372, 202, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_digit_overlay.md
# vga_digit_overlay

Parametrised VGA overlay address generator for the clock/chronometer display. Once per frame it burst-reads a bank of BCD-displayable registers from the time-keeping register file into a shadow bank and commits them atomically. It then maps each raster position to a glyph-ROM address for two-digit fields and a sprite-ROM address for on/off indicator flags. Cursor underlines blink, and everything else falls through to the background image address. It sits between the VGA sync counter (PosX/PosY) and the ROM/colour mux.

## Interface
Parameters:
- NUM_FIELDS, 9: two-digit numeric fields (sec, min, hour, day, month, year, chrono sec/min/hour).
- NUM_FLAGS, 2: single-bit indicator sprites (chrono active, chrono ring).
- FIELD_X / FIELD_Y, packed 10-bit per field, default X {218,128,38,132,232,416,519,429,339}, Y {288,288,288,130,130,130,288,288,288}: tens-digit origin.
- FLAG_X / FLAG_Y, packed 10-bit per flag, default X {338,500}, Y {370,370}.
- DIG_W 40, DIG_H 60, DIG_PITCH 42: glyph size and tens-to-ones offset.
- FLAG_W 100, FLAG_H 20: sprite size.
- CURSOR_H 5: underline rows.
- BLINK_FRAMES 32: frames per blink half-period.
- H_RES 640: background stride.
- ADDR_W 19, MEM_AW 4.

Ports:
- CLK  in  1  pixel clock.
- RESET  in  1  asynchronous, active-low reset.
- PosX  in  10  raster column.
- PosY  in  10  raster row.
- MemAddrOut  out  MEM_AW  register-file read address.
- MemRdEn  out  1  read strobe; data valid on MemDataIN the following cycle.
- MemDataIN  in  8  register-file read data.
- ROMAddrOut  out  ADDR_W  pixel address.
- ROMCS  out  2  00 background, 01 digit ROM, 11 flag ROM.
- Busy  out  1  fetch burst in progress.

## Operation
- Register map: NREG = NUM_FIELDS+NUM_FLAGS+1.
  - Addresses 1..NUM_FIELDS are fields.
  - The next NUM_FLAGS addresses are flags (bit 0 used).
  - The last address is the cursor: 0 = none, k = field k-1 underlined.
- Sequencer FSM:
  - IDLE to FETCH on PosX==0 && PosY==0.
  - FETCH issues MemRdEn with addresses 1..NREG on consecutive cycles and captures MemDataIN into the shadow bank one cycle after each strobe.
  - After the last capture, COMMIT copies shadow to live in one cycle and returns to IDLE.
  - Frame-start pulses while not in IDLE are ignored.
- Field decode:
  - value = MemDataIN[6:0].
  - Values 0..99 split to tens/ones digit indices 0..9.
  - Values 100..127 display index 10 (dash) in both digits.
  - Live bank stores row offsets (index*DIG_H), 10 bits per digit.
- Windows are half-open: [X, X+W) and [Y, Y+H). Priority is fields ascending (tens before ones), then flags ascending, then background.
- Digit address = (PosX−Xd) + DIG_W*((PosY−Y) + offset), CS=01. Xd = X for tens, X+DIG_PITCH for ones.
- Flag address = (PosX−X) + FLAG_W*((PosY−Y) + bit*FLAG_H), CS=11.
- Background address = PosX + H_RES*PosY, CS=00.
- Cursor: rows with PosY ≥ Y+DIG_H−CURSOR_H in both digits of the selected field output background while blink phase = 1. Cursor values > NUM_FIELDS are treated as none.
- Blink: a frame counter increments at each COMMIT; blink phase toggles when the counter wraps at BLINK_FRAMES−1.
- All arithmetic is done at ADDR_W bits; no overflow occurs for the default parameters.

## Timing
- ROMAddrOut/ROMCS are registered: 1-cycle latency from PosX/PosY, using the live bank as of that cycle.
- Burst for a frame start sampled at cycle 0:
  - MemRdEn high in cycles 1..NREG.
  - Captures in cycles 2..NREG+1.
  - Commit at edge NREG+2.
  - Busy high in cycles 1..NREG+2.
- Reset (asynchronous, mid-burst included): FSM to IDLE, shadow and live banks 0, cursor 0, blink counter and phase 0, MemRdEn 0, MemAddrOut 0, ROMAddrOut 0, ROMCS 00, Busy 0. An aborted burst leaves the live bank untouched (zero).
- Live bank changes only at COMMIT, so there is no intra-frame tearing.

## Structure
- Package vga_overlay_pkg holds:
  - ROMCS encodings (CS_BG, CS_DIG, CS_FLAG).
  - DASH_INDEX = 10.
  - Default layout constants.
- Sub-module bcd_split (7-bit value → tens, ones, invalid) is instantiated once on MemDataIN, ahead of the shadow write.

## Test plan
- Reset, then frame start with field 0 = 37: MemRdEn asserts 1..12, Busy falls after cycle 14. At PosX=265, PosY=300, next cycle ROMAddrOut=17285, CS=01.
- Same bank, tens digit at PosX=220, PosY=288 → 7202, CS=01. PosX=10, PosY=5 → 3210, CS=00.
- Field 0 = 123 → both digits use dash: PosX=218, PosY=288 → 24000, CS=01.
- Flag 0 = 1, PosX=340, PosY=372 → 2202, CS=11. Flag 0 = 0 → 202.
- Cursor = 1, PosX=220, PosY=345:
  - Outputs CS=00 for BLINK_FRAMES frames after phase toggles to 1.
  - Outputs CS=01 during phase 0.
  - Cursor = 15 never blanks.
- Assert RESET mid-burst (cycle 5), release, no frame start: live bank 0, ROMCS 00, Busy 0. The next frame start commits normally.
